// File: rtl/wb_write_buffer_if.sv
// Wishbone line-wide bus bundle used on both sides of the posted write buffer.
//   adr    line address (master -> slave)
//   dat_m  write data   (master -> slave)
//   dat_s  read data    (slave -> master)
//   sel    byte enables (master -> slave)
//   cyc    bus cycle    (master -> slave)
//   stb    strobe       (master -> slave)
//   we     write enable (master -> slave)
//   ack    acknowledge  (slave -> master)
//   rty    retry        (slave -> master)
interface wb_write_buffer_if #(
    parameter int ADR_W  = 27,
    parameter int LINE_W = 256
);
    logic [ADR_W-1:0]    adr;
    logic [LINE_W-1:0]   dat_m;
    logic [LINE_W-1:0]   dat_s;
    logic [LINE_W/8-1:0] sel;
    logic                cyc;
    logic                stb;
    logic                we;
    logic                ack;
    logic                rty;

    modport master (
        output adr, dat_m, sel, cyc, stb, we,
        input  dat_s, ack, rty
    );

    modport slave (
        input  adr, dat_m, sel, cyc, stb, we,
        output dat_s, ack, rty
    );
endinterface

// File: rtl/wb_write_buffer.sv
// Posted write buffer between the cache arbiter (upstream wishbone master) and
// physical memory. Line write-backs are absorbed into a small circular FIFO and
// acked in one cycle; writes to an already-buffered line merge bytes into it;
// reads of a fully-valid buffered line are answered from the buffer; read misses
// go to memory ahead of queued writes unless a partially-valid buffered copy of
// the line forces it to drain first.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (discards all buffered writes)
//   s    upstream bus, slave side (s.rty is tied low)
//   m    memory bus, master side (m.stb always follows m.cyc)
module wb_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADR_W  = 27
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_buffer_if.slave  s,
    wb_write_buffer_if.master m
);
    localparam int SEL_W = LINE_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q;
    logic              valid_q [DEPTH];
    logic [ADR_W-1:0]  adr_q   [DEPTH];
    logic [LINE_W-1:0] data_q  [DEPTH];
    logic [SEL_W-1:0]  sel_q   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              s_ack_q;
    logic [LINE_W-1:0] s_dat_s_q;
    logic              m_cyc_q;
    logic              m_we_q;
    logic              retry_q;
    logic [ADR_W-1:0]  m_adr_q;
    logic [LINE_W-1:0] m_dat_m_q;
    logic [SEL_W-1:0]  m_sel_q;

    logic              req, wr, rd, mem_ack, pop;
    logic              hit, hit_full, head_busy;
    logic              do_merge, do_enq, rd_hit, rd_miss;
    logic              start_read, start_drain;
    logic [PTR_W-1:0]  hit_idx;

    // The master keeps its request up during the ack cycle; masking it there
    // prevents the same transfer from being taken twice.
    assign req     = s.cyc & s.stb & ~s_ack_q;
    assign wr      = req & s.we;
    assign rd      = req & ~s.we;
    assign mem_ack = m_cyc_q & m.ack;
    assign pop     = (state_q == DRAIN) & mem_ack;

    // The head being popped this cycle no longer counts as a match, so a
    // stalled write to that line is enqueued fresh in the same cycle.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (adr_q[i] == s.adr) &&
                !(pop && (PTR_W'(i) == head_q))) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign hit_full    = hit & (&sel_q[hit_idx]);
    assign rd_miss     = rd & ~hit;
    assign start_read  = (state_q == IDLE) & rd_miss;
    assign start_drain = (state_q == IDLE) & ~rd_miss & (count_q != '0);
    // The head is frozen from the cycle its fields are copied onto the memory
    // bus until the drain completes.
    assign head_busy   = hit & (hit_idx == head_q) & ((state_q == DRAIN) | start_drain);
    assign do_merge    = wr & hit & ~head_busy;
    assign do_enq      = wr & ~hit & ((count_q != CNT_W'(DEPTH)) | pop);
    assign rd_hit      = rd & hit_full & (state_q != READ);

    assign head_d  = head_q + PTR_W'(pop);
    assign tail_d  = tail_q + PTR_W'(do_enq);
    assign count_d = count_q + CNT_W'(do_enq) - CNT_W'(pop);

    assign s.ack   = s_ack_q;
    assign s.dat_s = s_dat_s_q;
    assign s.rty   = 1'b0;
    assign m.adr   = m_adr_q;
    assign m.dat_m = m_dat_m_q;
    assign m.sel   = m_sel_q;
    assign m.cyc   = m_cyc_q;
    assign m.stb   = m_cyc_q;
    assign m.we    = m_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
            s_ack_q   <= 1'b0;
            s_dat_s_q <= '0;
            m_cyc_q   <= 1'b0;
            m_we_q    <= 1'b0;
            retry_q   <= 1'b0;
            m_adr_q   <= '0;
            m_dat_m_q <= '0;
            m_sel_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Enqueue follows pop so a full-buffer pop+enqueue into the same
            // slot leaves it valid.
            if (pop)    valid_q[head_q] <= 1'b0;
            if (do_enq) valid_q[tail_q] <= 1'b1;

            s_ack_q <= do_enq | do_merge | rd_hit;
            if (rd_hit) s_dat_s_q <= data_q[hit_idx];

            case (state_q)
                IDLE: begin
                    if (start_read) begin
                        state_q <= READ;
                        m_cyc_q <= 1'b1;
                        m_we_q  <= 1'b0;
                        m_adr_q <= s.adr;
                        m_sel_q <= '1;
                    end else if (start_drain) begin
                        state_q   <= DRAIN;
                        m_cyc_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        m_adr_q   <= adr_q[head_q];
                        m_dat_m_q <= data_q[head_q];
                        m_sel_q   <= sel_q[head_q];
                    end
                end
                default: begin
                    // A retried transfer is re-presented unchanged after one
                    // cycle with m.cyc low.
                    if (retry_q) begin
                        m_cyc_q <= 1'b1;
                        retry_q <= 1'b0;
                    end else if (mem_ack) begin
                        state_q <= IDLE;
                        m_cyc_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        if (state_q == READ) begin
                            s_ack_q   <= 1'b1;
                            s_dat_s_q <= m.dat_s;
                        end
                    end else if (m_cyc_q && m.rty) begin
                        m_cyc_q <= 1'b0;
                        retry_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Entry payload carries no reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_merge) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (s.sel[b]) data_q[hit_idx][8*b +: 8] <= s.dat_m[8*b +: 8];
            end
            sel_q[hit_idx] <= sel_q[hit_idx] | s.sel;
        end
        if (do_enq) begin
            adr_q[tail_q]  <= s.adr;
            data_q[tail_q] <= s.dat_m;
            sel_q[tail_q]  <= s.sel;
        end
    end
endmodule

// File: tb/tb_wb_write_buffer.sv
// Testbench for wb_write_buffer: directed scenarios plus a randomized run
// checked against a flat byte-merged memory image.
module tb_wb_write_buffer;
    localparam int ADR_W  = 27;
    localparam int LINE_W = 256;
    localparam int SEL_W  = LINE_W / 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    wb_write_buffer_if #(.ADR_W(ADR_W), .LINE_W(LINE_W)) sb ();
    wb_write_buffer_if #(.ADR_W(ADR_W), .LINE_W(LINE_W)) mb ();

    wb_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADR_W(ADR_W)) dut (
        .clk (clk),
        .rst (rst),
        .s   (sb),
        .m   (mb)
    );

    typedef struct {
        bit                we;
        int                adr;
        logic [LINE_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
    } txn_t;

    txn_t              mlog[$];
    logic [LINE_W-1:0] phys [int];
    logic [LINE_W-1:0] gold [int];
    bit                mem_auto = 1'b0;
    int                ack_grant = 0;
    int                rty_grant = 0;
    int                ack_used = 0;
    int                rty_used = 0;
    bit                do_ack, do_rty;
    int                rnum;

    function automatic logic [LINE_W-1:0] init_line(input int adr);
        return {8{32'hA5A50000 | 32'(adr)}};
    endfunction

    function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0] old,
                                                      input logic [LINE_W-1:0] d,
                                                      input logic [SEL_W-1:0] sel);
        logic [LINE_W-1:0] r;
        r = old;
        for (int b = 0; b < SEL_W; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] get_phys(input int adr);
        if (phys.exists(adr)) return phys[adr];
        return init_line(adr);
    endfunction

    function automatic logic [LINE_W-1:0] get_gold(input int adr);
        if (gold.exists(adr)) return gold[adr];
        return init_line(adr);
    endfunction

    function automatic void gold_write(input int adr, input logic [LINE_W-1:0] d,
                                       input logic [SEL_W-1:0] sel);
        gold[adr] = merge_bytes(get_gold(adr), d, sel);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Memory model: answers at the falling edge so the DUT samples ack/rty on
    // the next rising edge. Manual mode answers only as many times as granted.
    always @(negedge clk) begin
        mb.ack = 1'b0;
        mb.rty = 1'b0;
        if (rst === 1'b0 && mb.cyc === 1'b1) begin
            if (mem_auto) begin
                rnum   = $urandom_range(0, 9);
                do_ack = (rnum < 4);
                do_rty = (rnum == 9);
            end else begin
                do_rty = (rty_used < rty_grant);
                do_ack = !do_rty && (ack_used < ack_grant);
            end
            if (do_rty) begin
                mb.rty = 1'b1;
                if (!mem_auto) rty_used++;
            end else if (do_ack) begin
                mb.ack = 1'b1;
                if (!mem_auto) ack_used++;
                if (mb.we) phys[int'(mb.adr)] = merge_bytes(get_phys(int'(mb.adr)), mb.dat_m, mb.sel);
                else       mb.dat_s = get_phys(int'(mb.adr));
                mlog.push_back('{we: mb.we, adr: int'(mb.adr), dat: mb.dat_m, sel: mb.sel});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input int adr, input logic [LINE_W-1:0] d, input logic [SEL_W-1:0] sel,
                             input int maxc, output bit acked, output int lat);
        @(posedge clk);
        @(negedge clk);
        sb.adr = ADR_W'(adr); sb.dat_m = d; sb.sel = sel;
        sb.we = 1'b1; sb.cyc = 1'b1; sb.stb = 1'b1;
        acked = 1'b0; lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk); #1;
            if (sb.ack) begin acked = 1'b1; lat = i; break; end
        end
        sb.cyc = 1'b0; sb.stb = 1'b0; sb.we = 1'b0;
    endtask

    task automatic bus_read(input int adr, input int maxc, output bit acked, output int lat,
                            output logic [LINE_W-1:0] d);
        @(posedge clk);
        @(negedge clk);
        sb.adr = ADR_W'(adr); sb.sel = '1;
        sb.we = 1'b0; sb.cyc = 1'b1; sb.stb = 1'b1;
        acked = 1'b0; lat = 0; d = '0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk); #1;
            if (sb.ack) begin acked = 1'b1; lat = i; d = sb.dat_s; break; end
        end
        sb.cyc = 1'b0; sb.stb = 1'b0;
    endtask

    task automatic wait_log(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (mlog.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (mlog.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (sb.ack !== 1'b0) begin fails++; $display("FAIL reset_s_ack: got %b required 0", sb.ack); end
        tests++; if (sb.dat_s !== '0) begin fails++; $display("FAIL reset_s_dat_s: got %h required 0", sb.dat_s); end
        tests++; if ({mb.cyc, mb.stb, mb.we} !== 3'b000) begin fails++; $display("FAIL reset_m_ctl: got %b required 000", {mb.cyc, mb.stb, mb.we}); end
        tests++; if (mb.adr !== '0 || mb.sel !== '0 || mb.dat_m !== '0) begin fails++; $display("FAIL reset_m_bus: got adr %h sel %h required 0", mb.adr, mb.sel); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_drain();
        bit ok; int lat; int base; logic [LINE_W-1:0] a;
        a = rand_line();
        base = mlog.size();
        bus_write(32'h10, a, '1, 10, ok, lat);
        gold_write(32'h10, a, '1);
        tests++; if (!ok || lat != 1) begin fails++; $display("FAIL wr_ack_latency: got acked %0b lat %0d required lat 1", ok, lat); end
        @(posedge clk); #1;
        tests++; if ({mb.cyc, mb.stb, mb.we} !== 3'b111) begin fails++; $display("FAIL drain_ctl: got %b required 111", {mb.cyc, mb.stb, mb.we}); end
        tests++; if (mb.adr !== ADR_W'(32'h10) || mb.dat_m !== a || mb.sel !== '1) begin fails++; $display("FAIL drain_fields: got adr %h data %h required adr 10 data %h", mb.adr, mb.dat_m, a); end
        ack_grant++;
        wait_log(base + 1, 20, ok);
        tests++; if (!ok || mlog[base].adr != 32'h10 || !mlog[base].we) begin fails++; $display("FAIL drain_done: got log %0d required %0d", mlog.size(), base + 1); end
        tests++; if (mb.cyc !== 1'b0) begin fails++; $display("FAIL drain_release: got m_cyc %b required 0", mb.cyc); end
    endtask

    task automatic test_read_forward();
        bit ok; int lat; int base; logic [LINE_W-1:0] b, d;
        b = rand_line();
        base = mlog.size();
        bus_write(32'h10, b, '1, 10, ok, lat);
        gold_write(32'h10, b, '1);
        @(posedge clk); #1;
        bus_read(32'h10, 10, ok, lat, d);
        tests++; if (!ok || lat != 1 || d !== b) begin fails++; $display("FAIL fwd_read: got acked %0b lat %0d data %h required lat 1 data %h", ok, lat, d, b); end
        tests++; if (mb.cyc !== 1'b1 || mb.we !== 1'b1) begin fails++; $display("FAIL fwd_no_mem_read: got cyc %b we %b required 1 1", mb.cyc, mb.we); end
        ack_grant++;
        wait_log(base + 1, 20, ok);
        tests++; if (!ok || !mlog[base].we) begin fails++; $display("FAIL fwd_drain: got log %0d required write entry", mlog.size()); end
    endtask

    task automatic test_partial_read();
        bit ok, okr, okl; int lat, latr, base; logic [LINE_W-1:0] c, d;
        c = rand_line();
        base = mlog.size();
        bus_write(32'h20, c, SEL_W'(32'h0000000F), 10, ok, lat);
        gold_write(32'h20, c, SEL_W'(32'h0000000F));
        fork
            bus_read(32'h20, 60, okr, latr, d);
            begin
                repeat (5) @(posedge clk);
                #1;
                ack_grant++;
                wait_log(base + 1, 30, okl);
                ack_grant++;
            end
        join
        tests++; if (!okr || latr <= 5 || d !== get_gold(32'h20)) begin fails++; $display("FAIL partial_read: got acked %0b lat %0d data %h required late ack data %h", okr, latr, d, get_gold(32'h20)); end
        tests++; if (mlog.size() < base + 2 || !mlog[base].we || mlog[base].sel !== SEL_W'(32'hF) || mlog[base + 1].we || mlog[base + 1].adr != 32'h20) begin fails++; $display("FAIL partial_order: got log size %0d required drain then read", mlog.size()); end
    endtask

    task automatic test_full_stall();
        bit ok, okw; int lat, latw, base;
        logic [LINE_W-1:0] d [5];
        base = mlog.size();
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_line();
            bus_write(i + 1, d[i], '1, 10, ok, lat);
            gold_write(i + 1, d[i], '1);
            tests++; if (!ok || lat != 1) begin fails++; $display("FAIL fill_ack_%0d: got acked %0b lat %0d required lat 1", i + 1, ok, lat); end
        end
        d[4] = rand_line();
        fork
            bus_write(5, d[4], '1, 40, okw, latw);
            begin
                repeat (6) @(posedge clk);
                #1;
                ack_grant++;
            end
        join
        gold_write(5, d[4], '1);
        tests++; if (!okw || latw <= 5) begin fails++; $display("FAIL full_stall: got acked %0b lat %0d required ack after first drain", okw, latw); end
        ack_grant += 4;
        wait_log(base + 5, 60, ok);
        for (int i = 0; i < 5; i++) begin
            tests++; if (!ok || mlog[base + i].adr != i + 1 || mlog[base + i].dat !== d[i]) begin fails++; $display("FAIL full_order_%0d: got log size %0d required adr %0d in order", i, mlog.size(), i + 1); end
        end
    endtask

    task automatic test_merge();
        bit ok; int lat, base, n30; logic [LINE_W-1:0] d0, d1, d2;
        d0 = rand_line(); d1 = rand_line(); d2 = rand_line();
        base = mlog.size();
        bus_write(32'h31, d0, '1, 10, ok, lat);
        gold_write(32'h31, d0, '1);
        bus_write(32'h30, d1, SEL_W'(32'h0000FFFF), 10, ok, lat);
        gold_write(32'h30, d1, SEL_W'(32'h0000FFFF));
        bus_write(32'h30, d2, SEL_W'(32'hFFFF0000), 10, ok, lat);
        gold_write(32'h30, d2, SEL_W'(32'hFFFF0000));
        tests++; if (!ok || lat != 1) begin fails++; $display("FAIL merge_ack: got acked %0b lat %0d required lat 1", ok, lat); end
        ack_grant += 2;
        wait_log(base + 2, 40, ok);
        repeat (4) @(posedge clk);
        #1;
        n30 = 0;
        for (int i = base; i < mlog.size(); i++) if (mlog[i].adr == 32'h30) n30++;
        tests++; if (!ok || n30 != 1) begin fails++; $display("FAIL merge_count: got %0d writes to 0x30 required 1", n30); end
        tests++; if (mlog[base + 1].sel !== '1 || mlog[base + 1].dat !== {d2[255:128], d1[127:0]}) begin fails++; $display("FAIL merge_data: got sel %h data %h required all-ones sel", mlog[base + 1].sel, mlog[base + 1].dat); end
    endtask

    task automatic test_retry();
        bit ok, seen; int lat, base; logic [LINE_W-1:0] d;
        d = rand_line();
        base = mlog.size();
        bus_write(32'h50, d, '1, 10, ok, lat);
        gold_write(32'h50, d, '1);
        @(posedge clk); #1;
        rty_grant++;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mb.cyc === 1'b0) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        tests++; if (!seen || mb.cyc !== 1'b1 || mb.adr !== ADR_W'(32'h50) || mb.dat_m !== d || mb.we !== 1'b1) begin fails++; $display("FAIL retry_reissue: got dropped %0b cyc %b adr %h required drop then same write", seen, mb.cyc, mb.adr); end
        ack_grant++;
        wait_log(base + 1, 20, ok);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (!ok || mlog.size() != base + 1 || mlog[base].adr != 32'h50) begin fails++; $display("FAIL retry_once: got log size %0d required %0d", mlog.size(), base + 1); end
    endtask

    task automatic test_random();
        bit ok; int lat, adr, idle; logic [LINE_W-1:0] d, rd; logic [SEL_W-1:0] sel;
        mem_auto = 1'b1;
        for (int n = 0; n < 120; n++) begin
            adr = 32'h60 + $urandom_range(0, 5);
            if ($urandom_range(0, 9) < 6) begin
                d = rand_line();
                case ($urandom_range(0, 2))
                    0: sel = '1;
                    1: sel = SEL_W'(32'h0000FFFF);
                    default: sel = SEL_W'($urandom());
                endcase
                bus_write(adr, d, sel, 300, ok, lat);
                if (ok) gold_write(adr, d, sel);
                tests++; if (!ok) begin fails++; $display("FAIL rnd_write_%0d: got no ack required ack adr %h", n, adr); end
            end else begin
                bus_read(adr, 300, ok, lat, rd);
                tests++; if (!ok || rd !== get_gold(adr)) begin fails++; $display("FAIL rnd_read_%0d: got %h required %h", n, rd, get_gold(adr)); end
            end
        end
        idle = 0;
        for (int i = 0; i < 600 && idle < 8; i++) begin
            @(posedge clk); #1;
            idle = (mb.cyc === 1'b0) ? idle + 1 : 0;
        end
        mem_auto = 1'b0;
        for (int a = 32'h60; a <= 32'h65; a++) begin
            tests++; if (get_phys(a) !== get_gold(a)) begin fails++; $display("FAIL rnd_mem_%h: got %h required %h", a, get_phys(a), get_gold(a)); end
        end
    endtask

    task automatic test_rst_drain();
        bit ok, busy; int lat, base; logic [LINE_W-1:0] d;
        d = rand_line();
        bus_write(32'h40, d, '1, 10, ok, lat);
        @(posedge clk); #1;
        tests++; if (mb.cyc !== 1'b1 || mb.adr !== ADR_W'(32'h40)) begin fails++; $display("FAIL rst_pre_drain: got cyc %b adr %h required 1 40", mb.cyc, mb.adr); end
        base = mlog.size();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (mb.cyc !== 1'b0 || mb.stb !== 1'b0) begin fails++; $display("FAIL rst_drop_cyc: got %b required 0", mb.cyc); end
        @(negedge clk);
        rst = 1'b0;
        ack_grant++;
        busy = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mb.cyc !== 1'b0) busy = 1'b1;
        end
        tests++; if (busy || mlog.size() != base) begin fails++; $display("FAIL rst_discard: got busy %0b writes %0d required 0 0", busy, mlog.size() - base); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sb.cyc = 1'b0; sb.stb = 1'b0; sb.we = 1'b0;
        sb.adr = '0; sb.dat_m = '0; sb.sel = '0;
        rst = 1'b1;
        test_reset();
        test_write_drain();
        test_read_forward();
        test_partial_read();
        test_full_stall();
        test_merge();
        test_retry();
        test_random();
        test_rst_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
